// File: rtl/down_timer_pkg.sv
// Shared state encodings and mode constants for the down-counting interval timer.
package down_timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } timer_state_e;

   localparam logic MODE_ONESHOT  = 1'b0;
   localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/down_timer_tick_prescaler.sv
// Prescaler for the down timer: one tick every prescale+1 cycles while run is high.
module tick_prescaler #(
   parameter int PRESCALE_W = 8
) (
   input  logic                  clock,
   input  logic                  clear_n,
   input  logic                  run,
   input  logic [PRESCALE_W-1:0] prescale,
   output logic                  tick
);

   logic [PRESCALE_W-1:0] presc_cnt;

   // prescale is compared live, so shrinking it mid-count ticks immediately
   assign tick = run && (presc_cnt >= prescale);

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         presc_cnt <= '0;
      end else if (!run || tick) begin
         presc_cnt <= '0;
      end else begin
         presc_cnt <= presc_cnt + PRESCALE_W'(1);
      end
   end

endmodule

// File: rtl/down_timer.sv
// Loadable down-counting timer with one-shot / periodic modes and terminal-count flags.
//  state   | meaning
//  IDLE    | stopped; load and start accepted
//  RUN     | counting down on prescaled ticks
//  DONE    | one-shot finished; done held until load or restart
module down_timer
   import down_timer_pkg::*;
#(
   parameter int WIDTH      = 4,
   parameter int PRESCALE_W = 8
) (
   input  logic                  clock,
   input  logic                  clear_n,
   input  logic                  load,
   input  logic [WIDTH-1:0]      load_value,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  mode,
   input  logic [PRESCALE_W-1:0] prescale,
   output logic [WIDTH-1:0]      count,
   output logic                  busy,
   output logic                  tc_pulse,
   output logic                  done
);

   timer_state_e     state;
   logic [WIDTH-1:0] reload;
   logic [WIDTH-1:0] eff_count;
   logic             tick;

   assign eff_count = load ? load_value : count;

   tick_prescaler #(.PRESCALE_W(PRESCALE_W)) u_presc (
      .clock    (clock),
      .clear_n  (clear_n),
      .run      (state == ST_RUN),
      .prescale (prescale),
      .tick     (tick)
   );

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         state    <= ST_IDLE;
         count    <= '0;
         reload   <= '0;
         busy     <= 1'b0;
         tc_pulse <= 1'b0;
         done     <= 1'b0;
      end else begin
         tc_pulse <= 1'b0;
         case (state)
            ST_IDLE, ST_DONE: begin
               if (load) begin
                  count  <= load_value;
                  reload <= load_value;
                  done   <= 1'b0;
               end
               if (start && !stop && (eff_count != '0)) begin
                  state <= ST_RUN;
                  busy  <= 1'b1;
                  done  <= 1'b0;
               end
            end
            ST_RUN: begin
               // a load while running only retargets the next periodic reload
               if (load) begin
                  reload <= load_value;
               end
               if (stop) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end else if (tick) begin
                  if (count > WIDTH'(1)) begin
                     count <= count - WIDTH'(1);
                  end else begin
                     tc_pulse <= 1'b1;
                     if ((mode == MODE_PERIODIC) && (reload != '0)) begin
                        count <= reload;
                     end else begin
                        count <= '0;
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer: vector table through a scoreboard queue, plus async-reset sequences.
module tb_down_timer;

   localparam int WIDTH      = 4;
   localparam int PRESCALE_W = 8;

   logic                  clock;
   logic                  clear_n;
   logic                  load;
   logic [WIDTH-1:0]      load_value;
   logic                  start;
   logic                  stop;
   logic                  mode;
   logic [PRESCALE_W-1:0] prescale;
   logic [WIDTH-1:0]      count;
   logic                  busy;
   logic                  tc_pulse;
   logic                  done;

   typedef struct {
      logic                  ld;
      logic [WIDTH-1:0]      lv;
      logic                  st;
      logic                  sp;
      logic                  md;
      logic [PRESCALE_W-1:0] pre;
      logic [WIDTH-1:0]      e_count;
      logic                  e_busy;
      logic                  e_tc;
      logic                  e_done;
      string                 name;
   } vec_t;

   typedef logic [WIDTH+2:0] obs_t;

   vec_t  vecs[$];
   obs_t  exp_q[$];
   string name_q[$];
   int    n_checks = 0;
   int    n_pass   = 0;

   down_timer #(.WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W)) dut (
      .clock      (clock),
      .clear_n    (clear_n),
      .load       (load),
      .load_value (load_value),
      .start      (start),
      .stop       (stop),
      .mode       (mode),
      .prescale   (prescale),
      .count      (count),
      .busy       (busy),
      .tc_pulse   (tc_pulse),
      .done       (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic vec_t mk(input logic ld, input logic [WIDTH-1:0] lv, input logic st,
                               input logic sp, input logic md, input logic [PRESCALE_W-1:0] pre,
                               input logic [WIDTH-1:0] ec, input logic eb, input logic et,
                               input logic ed, input string nm);
      vec_t v;
      v.ld = ld; v.lv = lv; v.st = st; v.sp = sp; v.md = md; v.pre = pre;
      v.e_count = ec; v.e_busy = eb; v.e_tc = et; v.e_done = ed; v.name = nm;
      return v;
   endfunction

   task automatic check(input string nm, input obs_t act, input obs_t exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got count/busy/tc/done=%h/%b/%b/%b want %h/%b/%b/%b", nm,
                    act[WIDTH+2:3], act[2], act[1], act[0],
                    exp[WIDTH+2:3], exp[2], exp[1], exp[0]);
   endtask

   // drive one vector at the falling edge, compare after the next rising edge
   task automatic apply(input vec_t v);
      obs_t  e;
      string nm;
      @(negedge clock);
      load = v.ld; load_value = v.lv; start = v.st; stop = v.sp;
      mode = v.md; prescale = v.pre;
      exp_q.push_back({v.e_count, v.e_busy, v.e_tc, v.e_done});
      name_q.push_back(v.name);
      @(posedge clock);
      #1;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      check(nm, {count, busy, tc_pulse, done}, e);
   endtask

   task automatic async_reset_check(input string nm);
      #2 clear_n = 1'b0;
      #1 check(nm, {count, busy, tc_pulse, done}, '0);
      @(negedge clock);
      clear_n = 1'b1;
   endtask

   initial begin
      clear_n = 1'b0; load = 0; load_value = '0; start = 0; stop = 0; mode = 0; prescale = '0;
      #12;
      check("reset_values", {count, busy, tc_pulse, done}, '0);
      @(negedge clock);
      clear_n = 1'b1;

      // 1: one-shot 5, prescale 0
      vecs.push_back(mk(1, 5, 1, 0, 0, 0, 5, 1, 0, 0, "os5_start"));
      for (int i = 4; i >= 1; i--) vecs.push_back(mk(0, 0, 0, 0, 0, 0, WIDTH'(i), 1, 0, 0, "os5_dec"));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, "os5_terminal"));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "os5_done_sticky"));
      vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, "done_start_zero_ignored"));

      // 2: periodic 3, prescale 1 -> 3,3,2,2,1,1 then reload with tc
      vecs.push_back(mk(1, 3, 1, 0, 1, 1, 3, 1, 0, 0, "per3_start"));
      for (int p = 0; p < 2; p++) begin
         if (p > 0) vecs.push_back(mk(0, 0, 0, 0, 1, 1, 3, 1, 0, 0, "per3_hold3"));
         else       vecs.push_back(mk(0, 0, 0, 0, 1, 1, 3, 1, 0, 0, "per3_first_hold"));
         vecs.push_back(mk(0, 0, 0, 0, 1, 1, 2, 1, 0, 0, "per3_c2a"));
         vecs.push_back(mk(0, 0, 0, 0, 1, 1, 2, 1, 0, 0, "per3_c2b"));
         vecs.push_back(mk(0, 0, 0, 0, 1, 1, 1, 1, 0, 0, "per3_c1a"));
         vecs.push_back(mk(0, 0, 0, 0, 1, 1, 1, 1, 0, 0, "per3_c1b"));
         vecs.push_back(mk(0, 0, 0, 0, 1, 1, 3, 1, 1, 0, "per3_reload_tc"));
      end
      vecs.push_back(mk(0, 0, 0, 1, 1, 1, 3, 0, 0, 0, "per3_stop"));

      // 3: all-ones one-shot, no wrap; then load 0 + start is ignored
      vecs.push_back(mk(1, 15, 1, 0, 0, 0, 15, 1, 0, 0, "os15_start"));
      for (int i = 14; i >= 1; i--) vecs.push_back(mk(0, 0, 0, 0, 0, 0, WIDTH'(i), 1, 0, 0, "os15_dec"));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, "os15_terminal"));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "os15_no_wrap"));
      vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, "load0_start_ignored"));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "load0_idle"));

      // 4: stop at count 2 holds, resume, start+stop stays idle
      vecs.push_back(mk(1, 3, 1, 0, 1, 0, 3, 1, 0, 0, "stop_start"));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, 2, 1, 0, 0, "stop_at2"));
      vecs.push_back(mk(0, 0, 0, 1, 1, 0, 2, 0, 0, 0, "stop_holds2"));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, 2, 0, 0, 0, "stop_idle2"));
      vecs.push_back(mk(0, 0, 1, 0, 1, 0, 2, 1, 0, 0, "resume_from2"));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 1, 0, 0, "resume_1"));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, 3, 1, 1, 0, "resume_reload"));
      vecs.push_back(mk(0, 0, 0, 1, 1, 0, 3, 0, 0, 0, "stop_again"));
      vecs.push_back(mk(0, 0, 1, 1, 1, 0, 3, 0, 0, 0, "start_stop_same"));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, 3, 0, 0, 0, "start_stop_idle"));

      // 5: reload 4, load 7 mid-run -> next period starts at 7
      vecs.push_back(mk(1, 4, 1, 0, 1, 0, 4, 1, 0, 0, "rl_start4"));
      vecs.push_back(mk(1, 7, 0, 0, 1, 0, 3, 1, 0, 0, "rl_load7_mid"));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, 2, 1, 0, 0, "rl_c2"));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 1, 0, 0, "rl_c1"));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, 7, 1, 1, 0, "rl_new7"));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, 6, 1, 0, 0, "rl_c6"));
      vecs.push_back(mk(0, 0, 0, 1, 1, 0, 6, 0, 0, 0, "rl_stop"));

      // periodic with reload 0 finishes like one-shot
      vecs.push_back(mk(1, 2, 1, 0, 1, 0, 2, 1, 0, 0, "rl0_start"));
      vecs.push_back(mk(1, 0, 0, 0, 1, 0, 1, 1, 0, 0, "rl0_load0"));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 1, "rl0_oneshot_end"));

      foreach (vecs[i]) apply(vecs[i]);

      // 6: async reset while done is set, then mid-run
      async_reset_check("async_reset_in_done");
      apply(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, "post_reset_start_ignored"));
      apply(mk(1, 9, 1, 0, 0, 2, 9, 1, 0, 0, "pre9_start"));
      apply(mk(0, 0, 0, 0, 0, 2, 9, 1, 0, 0, "pre9_wait1"));
      apply(mk(0, 0, 0, 0, 0, 2, 9, 1, 0, 0, "pre9_wait2"));
      apply(mk(0, 0, 0, 0, 0, 2, 8, 1, 0, 0, "pre9_dec"));
      async_reset_check("async_reset_mid_run");
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "post_reset_idle"));
      apply(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, "post_reset_needs_load"));
      apply(mk(1, 2, 1, 0, 0, 0, 2, 1, 0, 0, "post_reset_load_start"));
      apply(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, "post_reset_dec"));
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, "post_reset_terminal"));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
